rq_arbiter: RTL and testbench



---
 rtl/rq_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rq_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rq_arbiter.sv
// rq_arbiter: packet-level round-robin arbiter that lets NUM_REQ request
// sources share the single logic-side interface of the RQ formatter.
// The grant is held from the sop beat until the handshaked last beat, so
// multi-beat write payloads are never interleaved with other traffic.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               per-requester packed request fields, slice i per source
//   req_valid/sop/last  per-requester beat qualifiers
//   req_ready           beat accepted from requester i (owner only)
//   cfg_requester_id    Bus:Dev:Func, forwarded on rq_requester_id
//   rq_*                muxed request stream towards the RQ formatter
//   rq_ready            backpressure from the RQ formatter
//   grant               one-hot current owner, 0 when idle
//   err_sop_missing     sticky: a valid beat without sop was seen while idle
module rq_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*4-1:0]          req_type,
  input  logic [NUM_REQ*64-1:0]         req_addr,
  input  logic [NUM_REQ*11-1:0]         req_dword_count,
  input  logic [NUM_REQ*8-1:0]          req_tag,
  input  logic [NUM_REQ*3-1:0]          req_tc,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_sop,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [15:0]                   cfg_requester_id,
  output logic [3:0]                    rq_type,
  output logic [63:0]                   rq_addr,
  output logic [10:0]                   rq_dword_count,
  output logic [7:0]                    rq_tag,
  output logic [2:0]                    rq_tc,
  output logic [15:0]                   rq_requester_id,
  output logic [DATA_WIDTH-1:0]         rq_wr_data,
  output logic                          rq_valid,
  output logic                          rq_sop,
  output logic                          rq_last,
  input  logic                          rq_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          err_sop_missing
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic                 r_err;

  logic                 w_busy;
  logic [NUM_REQ-1:0]   w_cand;
  logic [NUM_REQ-1:0]   w_bad;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_scan_idx;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic                 w_xfer_last;

  // Per-requester views of the packed request buses.
  logic [3:0]            w_type  [NUM_REQ];
  logic [63:0]           w_addr  [NUM_REQ];
  logic [10:0]           w_dw    [NUM_REQ];
  logic [7:0]            w_tag   [NUM_REQ];
  logic [2:0]            w_tc    [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_type[gi] = req_type[gi*4 +: 4];
    assign w_addr[gi] = req_addr[gi*64 +: 64];
    assign w_dw[gi]   = req_dword_count[gi*11 +: 11];
    assign w_tag[gi]  = req_tag[gi*8 +: 8];
    assign w_tc[gi]   = req_tc[gi*3 +: 3];
    assign w_data[gi] = req_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_busy = (r_state == S_BUSY);
  assign w_cand = req_valid & req_sop;
  assign w_bad  = req_valid & ~req_sop;

  // Round-robin search: first candidate strictly after the last owner.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && w_cand[w_scan_idx]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_pick_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pick_oh[i] = (w_pick == IDX_W'(i));
    end
  end

  // Owner's fields pass straight through while busy; everything is 0 when idle.
  always_comb begin
    rq_type         = '0;
    rq_addr         = '0;
    rq_dword_count  = '0;
    rq_tag          = '0;
    rq_tc           = '0;
    rq_requester_id = '0;
    rq_wr_data      = '0;
    rq_valid        = 1'b0;
    rq_sop          = 1'b0;
    rq_last         = 1'b0;
    if (w_busy) begin
      rq_type         = w_type[r_owner];
      rq_addr         = w_addr[r_owner];
      rq_dword_count  = w_dw[r_owner];
      rq_tag          = w_tag[r_owner];
      rq_tc           = w_tc[r_owner];
      rq_requester_id = cfg_requester_id;
      rq_wr_data      = w_data[r_owner];
      rq_valid        = req_valid[r_owner];
      rq_sop          = req_sop[r_owner];
      rq_last         = req_last[r_owner];
    end
  end

  assign w_xfer_last = rq_valid & rq_ready & rq_last;

  // r_grant is zero outside BUSY, so only the owner ever sees ready.
  assign req_ready       = r_grant & {NUM_REQ{rq_ready}};
  assign grant           = r_grant;
  assign err_sop_missing = r_err;

  // Arbitration FSM: decide in IDLE, hold the owner until its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (|w_bad)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_xfer_last) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= r_owner;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rq_arbiter.sv
// Scoreboard bench for rq_arbiter: per-requester drivers replay queued beats,
// expected beats are queued in hand-derived arbitration order and a monitor
// compares every handshaked rq beat against the head of that queue.
module tb_rq_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = 256;

  logic              clk;
  logic              rst;
  logic [NR*4-1:0]   req_type;
  logic [NR*64-1:0]  req_addr;
  logic [NR*11-1:0]  req_dword_count;
  logic [NR*8-1:0]   req_tag;
  logic [NR*3-1:0]   req_tc;
  logic [NR*DW-1:0]  req_wr_data;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_sop;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [15:0]       cfg_requester_id;
  logic [3:0]        rq_type;
  logic [63:0]       rq_addr;
  logic [10:0]       rq_dword_count;
  logic [7:0]        rq_tag;
  logic [2:0]        rq_tc;
  logic [15:0]       rq_requester_id;
  logic [DW-1:0]     rq_wr_data;
  logic              rq_valid;
  logic              rq_sop;
  logic              rq_last;
  logic              rq_ready;
  logic [NR-1:0]     grant;
  logic              err_sop_missing;

  rq_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_type(req_type), .req_addr(req_addr), .req_dword_count(req_dword_count),
    .req_tag(req_tag), .req_tc(req_tc), .req_wr_data(req_wr_data),
    .req_valid(req_valid), .req_sop(req_sop), .req_last(req_last),
    .req_ready(req_ready), .cfg_requester_id(cfg_requester_id),
    .rq_type(rq_type), .rq_addr(rq_addr), .rq_dword_count(rq_dword_count),
    .rq_tag(rq_tag), .rq_tc(rq_tc), .rq_requester_id(rq_requester_id),
    .rq_wr_data(rq_wr_data), .rq_valid(rq_valid), .rq_sop(rq_sop),
    .rq_last(rq_last), .rq_ready(rq_ready), .grant(grant),
    .err_sop_missing(err_sop_missing)
  );

  typedef struct {
    logic [3:0]  typ;
    logic [63:0] addr;
    logic [10:0] dw;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [DW-1:0] data;
    logic        sop;
    logic        last;
    bit          junk;
    int          life;
    int          owner;
  } beat_t;

  beat_t bq0[$];
  beat_t bq1[$];
  beat_t exp_q[$];
  int    hs_cyc[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_hs     = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic beat_t zero_beat();
    beat_t b;
    b.typ = '0; b.addr = '0; b.dw = '0; b.tag = '0; b.tc = '0; b.data = '0;
    b.sop = 1'b0; b.last = 1'b0; b.junk = 1'b0; b.life = 0; b.owner = 0;
    return b;
  endfunction

  function automatic beat_t mk(input int r, input logic [3:0] typ, input logic [63:0] addr,
                               input logic [10:0] dw, input logic [7:0] tag,
                               input int k, input int n, input bit junk);
    beat_t b;
    b = zero_beat();
    b.typ = typ; b.addr = addr; b.dw = dw; b.tag = tag; b.tc = 3'(r + 1);
    for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = {tag, 8'(r), 8'(k), 8'(w)};
    b.sop = junk ? 1'b0 : (k == 0);
    b.last = (k == n - 1);
    b.junk = junk; b.life = 2; b.owner = r;
    return b;
  endfunction

  // Queue one packet on requester r; junk beats are never expected at the output.
  task automatic send(input int r, input logic [3:0] typ, input logic [63:0] addr,
                      input logic [10:0] dw, input logic [7:0] tag, input int n, input bit junk);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b = mk(r, typ, addr + 64'(k * 32), dw, tag, k, n, junk);
      if (r == 0) bq0.push_back(b); else bq1.push_back(b);
      if (!junk) exp_q.push_back(b);
    end
  endtask

  task automatic set_lane(input int i, input bit v, input beat_t b);
    req_valid[i] = v;
    req_sop[i]   = v & b.sop;
    req_last[i]  = v & b.last;
    req_type[i*4 +: 4]          = b.typ;
    req_addr[i*64 +: 64]        = b.addr;
    req_dword_count[i*11 +: 11] = b.dw;
    req_tag[i*8 +: 8]           = b.tag;
    req_tc[i*3 +: 3]            = b.tc;
    req_wr_data[i*DW +: DW]     = b.data;
  endtask

  // Requester drivers: retire a beat after its handshake, present the next one.
  initial begin : driver
    logic [NR-1:0] hs;
    set_lane(0, 1'b0, zero_beat());
    set_lane(1, 1'b0, zero_beat());
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && bq0.size() > 0) void'(bq0.pop_front());
      if (hs[1] && bq1.size() > 0) void'(bq1.pop_front());
      if (bq0.size() > 0 && bq0[0].junk) begin
        if (bq0[0].life == 0) void'(bq0.pop_front()); else bq0[0].life = bq0[0].life - 1;
      end
      if (bq1.size() > 0 && bq1[0].junk) begin
        if (bq1[0].life == 0) void'(bq1.pop_front()); else bq1[0].life = bq1[0].life - 1;
      end
      if (bq0.size() > 0) set_lane(0, 1'b1, bq0[0]); else set_lane(0, 1'b0, zero_beat());
      if (bq1.size() > 0) set_lane(1, 1'b1, bq1[0]); else set_lane(1, 1'b0, zero_beat());
    end
  end

  // Monitor: every rq handshake must match the head of the expected queue.
  initial begin : monitor
    beat_t e;
    logic [NR-1:0] eg;
    forever begin
      @(negedge clk);
      if (!rst && rq_valid && rq_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          eg = '0;
          eg[e.owner] = 1'b1;
          chk("mon_grant", DW'(grant), DW'(eg));
          chk("mon_req_ready", DW'(req_ready), DW'(eg));
          chk("mon_type", DW'(rq_type), DW'(e.typ));
          chk("mon_addr", DW'(rq_addr), DW'(e.addr));
          chk("mon_dw", DW'(rq_dword_count), DW'(e.dw));
          chk("mon_tag", DW'(rq_tag), DW'(e.tag));
          chk("mon_tc", DW'(rq_tc), DW'(e.tc));
          chk("mon_data", rq_wr_data, e.data);
          chk("mon_sop", DW'(rq_sop), DW'(e.sop));
          chk("mon_last", DW'(rq_last), DW'(e.last));
          chk("mon_reqid", DW'(rq_requester_id), DW'(cfg_requester_id));
          hs_cyc.push_back(cyc);
          n_hs++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && bq0.size() == 0 && bq1.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("drain", DW'(done), DW'(1));
    tick();
    tick();
  endtask

  task automatic wait_hs(input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (n_hs >= target) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_handshake", DW'(done), DW'(1));
  endtask

  task automatic clear_all();
    exp_q.delete();
    bq0.delete();
    bq1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin : main
    int base;
    bit seen;
    rst = 1'b1;
    rq_ready = 1'b1;
    cfg_requester_id = 16'hBEEF;

    // Reset state, held and after release.
    repeat (3) tick();
    chk("rst_grant", DW'(grant), DW'(0));
    chk("rst_rq_valid", DW'(rq_valid), DW'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_grant", DW'(grant), DW'(0));
    chk("idle_rq_valid", DW'(rq_valid), DW'(0));
    chk("idle_req_ready", DW'(req_ready), DW'(0));
    chk("idle_err", DW'(err_sop_missing), DW'(0));
    chk("idle_addr_zero", DW'(rq_addr), DW'(0));
    chk("idle_data_zero", rq_wr_data, DW'(0));

    // Single read from requester 0: one-cycle grant decision.
    send(0, 4'b0000, 64'h1000, 11'd1, 8'd5, 1, 1'b0);
    tick();
    chk("rd_grant_decide", DW'(grant), DW'(0));
    tick();
    chk("rd_grant", DW'(grant), DW'(2'b01));
    chk("rd_rq_valid", DW'(rq_valid), DW'(1));
    chk("rd_addr", DW'(rq_addr), DW'(64'h1000));
    tick();
    chk("rd_back_idle", DW'(grant), DW'(0));
    chk("rd_valid_idle", DW'(rq_valid), DW'(0));
    wait_drain(20);

    // Multi-beat write from requester 1; requester 0 must wait for its last beat.
    base = n_hs;
    send(1, 4'b0001, 64'h2000, 11'd32, 8'h21, 4, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (grant == 2'b10) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("wr_granted", DW'(seen), DW'(1));
    send(0, 4'b0000, 64'h3000, 11'd4, 8'h07, 1, 1'b0);
    tick();
    chk("wr_hold_grant", DW'(grant), DW'(2'b10));
    chk("wr_req0_not_ready", DW'(req_ready[0]), DW'(0));
    wait_drain(40);
    chk("wr_beats", DW'(n_hs - base), DW'(5));
    if (n_hs - base == 5) begin
      chk("wr_no_gap", DW'(hs_cyc[base+3] - hs_cyc[base]), DW'(3));
      chk("wr_bubble", DW'(hs_cyc[base+4] - hs_cyc[base+3]), DW'(2));
    end

    // Round-robin after reset: requester 0 first, alternate with one bubble.
    do_reset();
    base = n_hs;
    for (int p = 0; p < 3; p++) begin
      send(0, 4'b0000, 64'h4000 + 64'(p * 64'h100), 11'd2, 8'(8'h40 + p), 1, 1'b0);
      send(1, 4'b0000, 64'h5000 + 64'(p * 64'h100), 11'd3, 8'(8'h50 + p), 1, 1'b0);
    end
    wait_drain(60);
    chk("rr_count", DW'(n_hs - base), DW'(6));
    if (n_hs - base == 6) begin
      for (int k = 1; k < 6; k++) chk("rr_spacing", DW'(hs_cyc[base+k] - hs_cyc[base+k-1]), DW'(2));
    end

    // Backpressure: 5 stalled cycles on beat 1 of a 3-beat write.
    base = n_hs;
    send(1, 4'b0001, 64'h6000, 11'd24, 8'h61, 3, 1'b0);
    wait_hs(base + 1, 20);
    rq_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_req_ready", DW'(req_ready), DW'(0));
      chk("bp_grant", DW'(grant), DW'(2'b10));
      tick();
    end
    chk("bp_stalled_count", DW'(n_hs - base), DW'(1));
    rq_ready = 1'b1;
    wait_drain(30);
    chk("bp_beats", DW'(n_hs - base), DW'(3));

    // Protocol error: valid without sop in IDLE is refused and flagged.
    send(0, 4'b0000, 64'h7000, 11'd1, 8'h70, 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("err_no_grant", DW'(grant), DW'(0));
    end
    chk("err_set", DW'(err_sop_missing), DW'(1));
    wait_drain(10);
    send(0, 4'b0000, 64'h7100, 11'd1, 8'h71, 1, 1'b0);
    send(1, 4'b0000, 64'h7200, 11'd1, 8'h72, 1, 1'b0);
    wait_drain(30);
    chk("err_sticky", DW'(err_sop_missing), DW'(1));

    // Reset mid-packet: requester 0 last served, so without reset 1 would win next.
    send(0, 4'b0000, 64'h8000, 11'd1, 8'h80, 1, 1'b0);
    wait_drain(20);
    base = n_hs;
    send(1, 4'b0001, 64'h9000, 11'd32, 8'h90, 4, 1'b0);
    wait_hs(base + 2, 20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", DW'(rq_valid), DW'(0));
    chk("mid_rst_grant", DW'(grant), DW'(0));
    chk("mid_rst_ready", DW'(req_ready), DW'(0));
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_err", DW'(err_sop_missing), DW'(0));
    chk("post_rst_grant", DW'(grant), DW'(0));
    send(0, 4'b0000, 64'hA000, 11'd1, 8'hA0, 1, 1'b0);
    send(1, 4'b0000, 64'hB000, 11'd1, 8'hB0, 1, 1'b0);
    wait_drain(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
